// File: rtl/sp_bank_rw_engine_if.sv
// Bank port bundle: show-ahead write/read FIFO pop ports plus the store and GEMM output handshakes.
// The slave modport is the engine side; the master modport is the FIFO/consumer environment.
interface sp_bank_rw_engine_if #(
    parameter int MAT_S_W = 2,
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 32
);
    logic                wFIFO_empty;
    logic                wFIFO_REN;
    logic                wFIFO_gemm_result;
    logic [MAT_S_W-1:0]  wFIFO_mat_s;
    logic [1:0]          wFIFO_row_s;
    logic [DATA_W-1:0]   wFIFO_data;

    logic                rFIFO_empty;
    logic                rFIFO_REN;
    logic [ADDR_W-1:0]   rFIFO_addr;
    logic [1:0]          rFIFO_mat_t;
    logic [MAT_S_W-1:0]  rFIFO_mat_s;
    logic [1:0]          rFIFO_row_s;

    logic                st_valid;
    logic                st_ready;
    logic [ADDR_W-1:0]   st_addr;
    logic [1:0]          st_row;
    logic [DATA_W-1:0]   st_data;

    logic                gm_valid;
    logic                gm_ready;
    logic [1:0]          gm_type;
    logic [1:0]          gm_row;
    logic [DATA_W-1:0]   gm_data;

    logic [7:0]          bank_id;

    modport slave (
        input  wFIFO_empty, wFIFO_gemm_result, wFIFO_mat_s, wFIFO_row_s, wFIFO_data,
        output wFIFO_REN,
        input  rFIFO_empty, rFIFO_addr, rFIFO_mat_t, rFIFO_mat_s, rFIFO_row_s,
        output rFIFO_REN,
        output st_valid, st_addr, st_row, st_data,
        input  st_ready,
        output gm_valid, gm_type, gm_row, gm_data,
        input  gm_ready,
        output bank_id
    );

    modport master (
        output wFIFO_empty, wFIFO_gemm_result, wFIFO_mat_s, wFIFO_row_s, wFIFO_data,
        input  wFIFO_REN,
        output rFIFO_empty, rFIFO_addr, rFIFO_mat_t, rFIFO_mat_s, rFIFO_row_s,
        input  rFIFO_REN,
        input  st_valid, st_addr, st_row, st_data,
        output st_ready,
        input  gm_valid, gm_type, gm_row, gm_data,
        output gm_ready,
        input  bank_id
    );
endinterface

// File: rtl/sp_bank_rw_engine.sv
// Scratchpad bank: 4x4 row store, one write or one read per cycle, reads land in output regs 1 cycle after pop.
// Outputs hold under back-pressure; a read waits until its destination register is free or draining.
module sp_bank_rw_engine #(
    parameter int BANK_NUM = 0,
    parameter int MAT_S_W  = 2,
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    sp_bank_rw_engine_if.slave   bus
);
    localparam int IDX_W = MAT_S_W + 2;
    localparam int ROWS  = 1 << IDX_W;

    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, STALL = 2'd3} state_t;

    state_t              state_q, state_d;
    logic                last_grant_q;       // 1 = read was granted last
    logic [DATA_W-1:0]   rows_q [ROWS];

    logic                st_valid_q, gm_valid_q;
    logic [ADDR_W-1:0]   st_addr_q;
    logic [1:0]          st_row_q, gm_row_q, gm_type_q;
    logic [DATA_W-1:0]   st_data_q, gm_data_q;

    logic                w_pend, r_pend, r_to_st, st_free, gm_free, r_elig;
    logic                grant_w, grant_r;
    logic [IDX_W-1:0]    widx, ridx;

    // Entries are stored the same way whether or not they come from GEMM.
    wire unused_gemm_result = bus.wFIFO_gemm_result;

    assign widx = {bus.wFIFO_mat_s, bus.wFIFO_row_s};
    assign ridx = {bus.rFIFO_mat_s, bus.rFIFO_row_s};

    always_comb begin
        w_pend  = !bus.wFIFO_empty;
        r_pend  = !bus.rFIFO_empty;
        r_to_st = (bus.rFIFO_mat_t == 2'd0);
        st_free = !st_valid_q || bus.st_ready;
        gm_free = !gm_valid_q || bus.gm_ready;
        r_elig  = r_pend && (r_to_st ? st_free : gm_free);
        grant_w = w_pend && (!r_elig || last_grant_q);
        grant_r = r_elig && (!w_pend || !last_grant_q);

        state_d = IDLE;
        if (grant_w)
            state_d = WRITE;
        else if (grant_r)
            state_d = READ;
        else if (r_pend && !w_pend)
            state_d = STALL;
    end

    // Pops are suppressed immediately while reset is held so no entry is lost.
    assign bus.wFIFO_REN = grant_w && !RST;
    assign bus.rFIFO_REN = grant_r && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            st_valid_q   <= 1'b0;
            st_addr_q    <= '0;
            st_row_q     <= '0;
            st_data_q    <= '0;
            gm_valid_q   <= 1'b0;
            gm_type_q    <= '0;
            gm_row_q     <= '0;
            gm_data_q    <= '0;
            for (int i = 0; i < ROWS; i++)
                rows_q[i] <= '0;
        end else begin
            state_q <= state_d;

            if (grant_w) begin
                rows_q[widx] <= bus.wFIFO_data;
                last_grant_q <= 1'b0;
            end
            if (grant_r)
                last_grant_q <= 1'b1;

            if (grant_r && r_to_st) begin
                st_valid_q <= 1'b1;
                st_addr_q  <= bus.rFIFO_addr;
                st_row_q   <= bus.rFIFO_row_s;
                st_data_q  <= rows_q[ridx];
            end else if (st_valid_q && bus.st_ready) begin
                st_valid_q <= 1'b0;
            end

            if (grant_r && !r_to_st) begin
                gm_valid_q <= 1'b1;
                gm_type_q  <= bus.rFIFO_mat_t;
                gm_row_q   <= bus.rFIFO_row_s;
                gm_data_q  <= rows_q[ridx];
            end else if (gm_valid_q && bus.gm_ready) begin
                gm_valid_q <= 1'b0;
            end
        end
    end

    assign bus.st_valid = st_valid_q;
    assign bus.st_addr  = st_addr_q;
    assign bus.st_row   = st_row_q;
    assign bus.st_data  = st_data_q;
    assign bus.gm_valid = gm_valid_q;
    assign bus.gm_type  = gm_type_q;
    assign bus.gm_row   = gm_row_q;
    assign bus.gm_data  = gm_data_q;
    assign bus.bank_id  = 8'(BANK_NUM);
endmodule
